q_learning_controller: RTL

Episode/step sequencer for the Q-learning datapath. It runs NUM_EPISODES episodes of MAX_STEPS steps each. For every step it issues one valid-qualified command (episode index, step index, episode start state, random action) and waits for the datapath's completion pulse before issuing the next. After the last step of the last episode it pulses the Q-table dump enable and reports done, with a watchdog for a stalled datapath.

---
 rtl/q_learning_controller_pkg.sv | 28 ++
 rtl/q_learning_controller_if.sv | 34 +++
 rtl/q_learning_controller_lfsr16.sv | 21 ++
 rtl/q_learning_controller.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/q_learning_controller_pkg.sv
// Shared defaults, FSM encoding and LFSR helpers for the Q-learning episode/step sequencer.
package q_learning_controller_pkg;

    localparam int unsigned DefCounterWidth = 16;
    localparam int unsigned DefStatesWidth  = 4;
    localparam int unsigned DefActionsWidth = 2;
    localparam int unsigned DefNumEpisodes  = 100;
    localparam int unsigned DefMaxSteps     = 20;
    localparam int unsigned DefTimeout      = 255;
    localparam logic [15:0] DefLfsrSeed     = 16'hACE1;

    localparam logic [15:0] LfsrTaps = 16'hB400;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StFlush = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } ctrl_state_e;

    // Galois form, right shift.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LfsrTaps : 16'h0000);
    endfunction

endpackage

// File: rtl/q_learning_controller_if.sv
// Control/command bundle between the sequencer, its host and the Q-learning datapath.
interface q_learning_controller_if #(
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned STATES_WIDTH  = 4,
    parameter int unsigned ACTIONS_WIDTH = 2
);
    logic                     i_start;
    logic                     i_abort;
    logic                     i_dp_valid;
    logic                     o_dp_valid;
    logic [COUNTER_WIDTH-1:0] o_count;
    logic [COUNTER_WIDTH-1:0] o_step;
    logic [STATES_WIDTH-1:0]  o_first_st;
    logic [ACTIONS_WIDTH-1:0] o_at_random;
    logic                     o_write_file_en;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_error;

    // Controller side.
    modport slave (
        input  i_start, i_abort, i_dp_valid,
        output o_dp_valid, o_count, o_step, o_first_st, o_at_random,
        output o_write_file_en, o_busy, o_done, o_error
    );

    // Host / datapath side.
    modport master (
        output i_start, i_abort, i_dp_valid,
        input  o_dp_valid, o_count, o_step, o_first_st, o_at_random,
        input  o_write_file_en, o_busy, o_done, o_error
    );

endinterface

// File: rtl/q_learning_controller_lfsr16.sv
// 16-bit Galois LFSR with enable; only the asynchronous reset reloads the seed.
module lfsr16
    import q_learning_controller_pkg::*;
#(
    parameter logic [15:0] SEED = DefLfsrSeed
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (en) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/q_learning_controller.sv
// Episode/step sequencer: issues one command per step, waits for the datapath ack,
// then pulses the Q-table dump and done; a watchdog traps a stalled datapath.
module q_learning_controller
    import q_learning_controller_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH  = DefCounterWidth,
    parameter int unsigned STATES_WIDTH   = DefStatesWidth,
    parameter int unsigned ACTIONS_WIDTH  = DefActionsWidth,
    parameter int unsigned NUM_EPISODES   = DefNumEpisodes,
    parameter int unsigned MAX_STEPS      = DefMaxSteps,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeout,
    parameter logic [15:0] LFSR_SEED      = DefLfsrSeed
) (
    input logic                   clk,
    input logic                   rst_n,
    q_learning_controller_if.slave ctrl
);

    localparam int unsigned SaWidth = STATES_WIDTH + ACTIONS_WIDTH;
    localparam int unsigned WdWidth = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [COUNTER_WIDTH-1:0] LastEpisode = COUNTER_WIDTH'(NUM_EPISODES - 1);
    localparam logic [COUNTER_WIDTH-1:0] LastStep    = COUNTER_WIDTH'(MAX_STEPS - 1);
    localparam logic [WdWidth-1:0]       WdLast      = WdWidth'(TIMEOUT_CYCLES - 1);

    ctrl_state_e              state_q;
    logic [15:0]              lfsr;
    logic [WdWidth-1:0]       wd_q;
    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] step_q;
    logic [STATES_WIDTH-1:0]  first_st_q;
    logic [ACTIONS_WIDTH-1:0] at_random_q;
    logic                     dp_valid_q;
    logic                     write_file_en_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     error_q;

    logic [STATES_WIDTH-1:0]  lfsr_state;
    logic [ACTIONS_WIDTH-1:0] lfsr_action;

    assign lfsr_state  = lfsr[SaWidth-1:ACTIONS_WIDTH];
    assign lfsr_action = lfsr[ACTIONS_WIDTH-1:0];

    if (SaWidth < 16) begin : g_unused
        logic unused_lfsr_bits;
        assign unused_lfsr_bits = ^lfsr[15:SaWidth];
    end

    // The LFSR holds still during WAIT, so the value seen when entering ISSUE is
    // the one driven as the action for that step.
    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == StIssue),
        .state (lfsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            wd_q            <= '0;
            count_q         <= '0;
            step_q          <= '0;
            first_st_q      <= '0;
            at_random_q     <= '0;
            dp_valid_q      <= 1'b0;
            write_file_en_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            dp_valid_q      <= 1'b0;
            write_file_en_q <= 1'b0;
            done_q          <= 1'b0;
            if (ctrl.i_abort) begin
                state_q     <= StIdle;
                wd_q        <= '0;
                count_q     <= '0;
                step_q      <= '0;
                first_st_q  <= '0;
                at_random_q <= '0;
                busy_q      <= 1'b0;
                error_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (ctrl.i_start) begin
                            state_q     <= StIssue;
                            count_q     <= '0;
                            step_q      <= '0;
                            first_st_q  <= lfsr_state;
                            at_random_q <= lfsr_action;
                            dp_valid_q  <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    StIssue: begin
                        state_q <= StWait;
                        wd_q    <= '0;
                    end
                    StWait: begin
                        // An ack on the expiry cycle still counts as a completed step.
                        if (ctrl.i_dp_valid) begin
                            if (step_q == LastStep && count_q == LastEpisode) begin
                                state_q         <= StFlush;
                                write_file_en_q <= 1'b1;
                            end else begin
                                if (step_q == LastStep) begin
                                    count_q    <= count_q + COUNTER_WIDTH'(1);
                                    step_q     <= '0;
                                    first_st_q <= lfsr_state;
                                end else begin
                                    step_q <= step_q + COUNTER_WIDTH'(1);
                                end
                                state_q     <= StIssue;
                                at_random_q <= lfsr_action;
                                dp_valid_q  <= 1'b1;
                            end
                        end else if (wd_q == WdLast) begin
                            state_q <= StErr;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            wd_q <= wd_q + WdWidth'(1);
                        end
                    end
                    StFlush: begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                    StDone: begin
                        state_q     <= StIdle;
                        count_q     <= '0;
                        step_q      <= '0;
                        first_st_q  <= '0;
                        at_random_q <= '0;
                        busy_q      <= 1'b0;
                    end
                    StErr: begin
                        state_q <= StErr;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctrl.o_dp_valid      = dp_valid_q;
    assign ctrl.o_count         = count_q;
    assign ctrl.o_step          = step_q;
    assign ctrl.o_first_st      = first_st_q;
    assign ctrl.o_at_random     = at_random_q;
    assign ctrl.o_write_file_en = write_file_en_q;
    assign ctrl.o_busy          = busy_q;
    assign ctrl.o_done          = done_q;
    assign ctrl.o_error         = error_q;

endmodule
